instr_fetch: RTL

Instruction fetch stage sitting directly downstream of the PC register: it reads the current PC, fetches the 16-bit instruction at that address from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. It closes the loop back to the PC by driving its `PC_in` (`next_pc`) and `halt_sig` (`halt_sig`). The PC advances only in the cycle this block allows, so fetch, redirect and program halt are all sequenced here.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_timeout_ctr.sv | 42 ++++
 rtl/instr_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, PC step,
// halt opcode and the fetch controller state encoding.
// Imported by instr_fetch and fetch_timeout_ctr.
package fetch_pkg;

    localparam int         PC_W        = 16;
    localparam int         INSTR_W     = 16;
    localparam int         PC_STEP     = 2;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_HOLD   = 3'd2,
        S_LOAD   = 3'd3,
        S_HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Fetch watchdog: counts cycles spent waiting for an instruction memory ack.
// Latency: expired_o is combinational in the LIMIT-th consecutive start_i cycle.
// Backpressure: none; clear_i has priority over start_i.
// Ports: clk/rst (async active-high), start_i (count this cycle),
//        clear_i (restart count), expired_o (limit reached this cycle).
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier waiting cycles, so this cycle is
    // the LIMIT-th one when the count equals LIMIT-1.
    assign expired_o = start_i && !clear_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads imem at pc_cur over req/ack, hands the word to
// decode over valid/ready, and sequences PC advance, redirect and halt.
// Latency: ack in cycle N -> ir_valid in N+1; one instruction per 2 cycles
// with zero-wait memory.
// Backpressure: ir_ready low holds the instruction in HOLD with halt_sig=1
// and no new imem request.
// Optional feature: FETCH_TIMEOUT_EN adds a fetch watchdog (fetch_err,
// halt on expiry); without it FETCH waits forever and fetch_err is 0.
// Ports: pc_cur/next_pc/halt_sig close the loop with the PC register;
//        imem_* is the memory read port; ir_* is the decode handshake;
//        redirect_* comes from execute; fetch_err is the sticky timeout flag.
module instr_fetch #(
    parameter int          PC_W           = fetch_pkg::PC_W,
    parameter int          INSTR_W        = fetch_pkg::INSTR_W,
    parameter logic [3:0]  HALT_OPCODE    = fetch_pkg::HALT_OPCODE,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    next_pc,
    output logic               halt_sig,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               fetch_err
);

    import fetch_pkg::*;

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic               squash_q;
    logic               squash_d;
    logic [PC_W-1:0]    redirect_q;
    logic [PC_W-1:0]    redirect_d;
    logic [PC_W-1:0]    redirect_even;
    logic [PC_W-1:0]    pc_inc;
    logic               imem_req_q;
    logic               ir_valid_q;
    logic [INSTR_W-1:0] ir_data_q;
    logic [PC_W-1:0]    ir_pc_q;
    logic               capture;
    logic               timeout_exp;

    // Instructions are halfword aligned, so the target LSB is dropped.
    assign redirect_even = redirect_pc & ~PC_W'(1);
    assign pc_inc        = pc_cur + PC_W'(PC_STEP);

`ifdef FETCH_TIMEOUT_EN
    logic fetch_err_q;

    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .start_i   (state_q == S_FETCH),
        .clear_i   ((state_q != S_FETCH) || imem_ack),
        .expired_o (timeout_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_q <= 1'b0;
        end else if (timeout_exp) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout_exp = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        redirect_d = redirect_q;
        halt_sig   = 1'b1;
        next_pc    = pc_inc;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // The request in flight is never aborted; a redirect only
                // marks its data for discard.
                if (redirect_valid) begin
                    redirect_d = redirect_even;
                    squash_d   = 1'b1;
                end
                if (imem_ack) begin
                    squash_d = 1'b0;
                    if (squash_q || redirect_valid) begin
                        state_d = S_LOAD;
                    end else begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (timeout_exp) begin
                    state_d = S_HALTED;
                end
            end
            S_HOLD: begin
                // Redirect wins over a same-cycle handshake: the held
                // instruction is on the wrong path.
                if (redirect_valid) begin
                    redirect_d = redirect_even;
                    state_d    = S_LOAD;
                end else if (ir_ready) begin
                    if (ir_data_q[INSTR_W-1 -: 4] == HALT_OPCODE) begin
                        state_d = S_HALTED;
                    end else begin
                        halt_sig = 1'b0;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_LOAD: begin
                halt_sig = 1'b0;
                next_pc  = redirect_valid ? redirect_even : redirect_q;
                state_d  = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            squash_q   <= 1'b0;
            redirect_q <= '0;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            squash_q   <= squash_d;
            redirect_q <= redirect_d;
            imem_req_q <= (state_d == S_FETCH);
            ir_valid_q <= (state_d == S_HOLD);
            if (capture) begin
                ir_data_q <= imem_rdata;
                ir_pc_q   <= pc_cur;
            end
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_cur;
    assign ir_valid  = ir_valid_q;
    assign ir_data   = ir_data_q;
    assign ir_pc     = ir_pc_q;

endmodule
